// File: rtl/comb_str_pkg.sv
// Shared types and defaults for the comb_str response checker.
// The default golden table encodes y = sel ? C : B over index {sel,A,B,C,D}.
package comb_str_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] EXP_TABLE_DEF = 32'hCCCC_F0F0;
  localparam int unsigned VEC_TOTAL_DEF = 32'd32;

  function automatic logic [4:0] pack_idx(
    input logic sel,
    input logic a,
    input logic b,
    input logic c,
    input logic d
  );
    return {sel, a, b, c, d};
  endfunction

endpackage

// File: rtl/comb_str_checker_if.sv
// Stimulus/response bundle between the comb_str driver side and the checker.
// The master drives vectors and start; the slave (checker) returns the verdict.
interface comb_str_checker_if #(
  parameter int CNT_W = 6,
  parameter int ERR_W = 6
) ();

  logic             start;
  logic             sample_en;
  logic             sel;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic [31:0]      coverage;
  logic             first_fail_vld;
  logic [4:0]       first_fail_idx;
  logic             first_fail_y;

  modport master (
    output start, sample_en, sel, a, b, c, d, y,
    input  busy, done, pass, vec_cnt, err_cnt, coverage,
           first_fail_vld, first_fail_idx, first_fail_y
  );

  modport slave (
    input  start, sample_en, sel, a, b, c, d, y,
    output busy, done, pass, vec_cnt, err_cnt, coverage,
           first_fail_vld, first_fail_idx, first_fail_y
  );

endinterface

// File: rtl/comb_str_exp_lut.sv
// Golden model for comb_str: combinational lookup of the expected y per index.
// Kept separate so the reference table can be swapped without touching the FSM.
module comb_str_exp_lut
  import comb_str_pkg::*;
#(
  parameter logic [31:0] EXP_TABLE = EXP_TABLE_DEF
) (
  input  logic [4:0] idx,
  output logic       exp_y
);

  // Table lookup, one bit per index.
  always_comb begin
    exp_y = EXP_TABLE[idx];
  end

endmodule

// File: rtl/comb_str_checker.sv
// Self-checking response monitor for comb_str: compares y against a golden table,
// counts vectors and errors, tracks index coverage and delivers a done/pass verdict.
module comb_str_checker
  import comb_str_pkg::*;
#(
  parameter logic [31:0] EXP_TABLE = EXP_TABLE_DEF,
  parameter int unsigned VEC_TOTAL = VEC_TOTAL_DEF,
  parameter int          CNT_W     = 6,
  parameter int          ERR_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comb_str_checker_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_TOTAL - 32'd1);
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] vec_cnt_r, vec_cnt_nxt_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_nxt_s;
  logic [31:0]      cov_r, cov_nxt_s;
  logic             ff_vld_r, ff_vld_nxt_s;
  logic [4:0]       ff_idx_r, ff_idx_nxt_s;
  logic             ff_y_r, ff_y_nxt_s;
  logic             pass_r, pass_nxt_s;
  logic             busy_r, done_r;

  logic [4:0]       idx_s;
  logic             exp_y_s;
  logic             start_s;
  logic             hon_s;
  logic             mis_s;
  logic             last_s;

  assign idx_s = pack_idx(bus.sel, bus.a, bus.b, bus.c, bus.d);

  comb_str_exp_lut #(
    .EXP_TABLE (EXP_TABLE)
  ) u_lut (
    .idx   (idx_s),
    .exp_y (exp_y_s)
  );

  // Qualify start and strobes against the current state.
  always_comb begin
    start_s = bus.start && (state_r != ST_RUN);
    hon_s   = bus.sample_en && (state_r == ST_RUN);
    mis_s   = hon_s && (bus.y != exp_y_s);
    last_s  = hon_s && (vec_cnt_r == LAST_CNT);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_RUN;
        else         state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (start_s) state_nxt_s = ST_RUN;
        else         state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Counter, coverage and first-failure capture; a start clears everything.
  always_comb begin
    vec_cnt_nxt_s = vec_cnt_r;
    err_cnt_nxt_s = err_cnt_r;
    cov_nxt_s     = cov_r;
    ff_vld_nxt_s  = ff_vld_r;
    ff_idx_nxt_s  = ff_idx_r;
    ff_y_nxt_s    = ff_y_r;
    if (start_s) begin
      vec_cnt_nxt_s = CNT_ZERO;
      err_cnt_nxt_s = ERR_ZERO;
      cov_nxt_s     = 32'h0000_0000;
      ff_vld_nxt_s  = 1'b0;
      ff_idx_nxt_s  = 5'd0;
      ff_y_nxt_s    = 1'b0;
    end else if (hon_s) begin
      vec_cnt_nxt_s        = vec_cnt_r + CNT_ONE;
      cov_nxt_s[idx_s]     = 1'b1;
      if (mis_s && (err_cnt_r != ERR_MAX)) begin
        err_cnt_nxt_s = err_cnt_r + ERR_ONE;
      end else begin
        err_cnt_nxt_s = err_cnt_r;
      end
      if (mis_s && !ff_vld_r) begin
        ff_vld_nxt_s = 1'b1;
        ff_idx_nxt_s = idx_s;
        ff_y_nxt_s   = bus.y;
      end else begin
        ff_vld_nxt_s = ff_vld_r;
      end
    end else begin
      vec_cnt_nxt_s = vec_cnt_r;
    end
  end

  // Verdict is formed from the post-update totals on the DONE-entry edge, then held.
  always_comb begin
    pass_nxt_s = 1'b0;
    if (start_s) begin
      pass_nxt_s = 1'b0;
    end else if (last_s) begin
      pass_nxt_s = (err_cnt_nxt_s == ERR_ZERO) && (&cov_nxt_s);
    end else if (state_r == ST_DONE) begin
      pass_nxt_s = pass_r;
    end else begin
      pass_nxt_s = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      vec_cnt_r <= CNT_ZERO;
      err_cnt_r <= ERR_ZERO;
      cov_r     <= 32'h0000_0000;
      ff_vld_r  <= 1'b0;
      ff_idx_r  <= 5'd0;
      ff_y_r    <= 1'b0;
      pass_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      vec_cnt_r <= vec_cnt_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
      cov_r     <= cov_nxt_s;
      ff_vld_r  <= ff_vld_nxt_s;
      ff_idx_r  <= ff_idx_nxt_s;
      ff_y_r    <= ff_y_nxt_s;
      pass_r    <= pass_nxt_s;
      busy_r    <= (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.vec_cnt        = vec_cnt_r;
  assign bus.err_cnt        = err_cnt_r;
  assign bus.coverage       = cov_r;
  assign bus.first_fail_vld = ff_vld_r;
  assign bus.first_fail_idx = ff_idx_r;
  assign bus.first_fail_y   = ff_y_r;

endmodule

// File: tb/tb_comb_str_checker.sv
// Directed bench for comb_str_checker: a default instance and a small
// saturating instance (ERR_W=4, VEC_TOTAL=20) share clock and reset.
module tb_comb_str_checker;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nmis;
  logic [31:0] tbl;

  comb_str_checker_if #(.CNT_W(6), .ERR_W(6)) bus1 ();
  comb_str_checker_if #(.CNT_W(6), .ERR_W(4)) bus2 ();

  comb_str_checker #(
    .EXP_TABLE (32'hCCCC_F0F0),
    .VEC_TOTAL (32),
    .CNT_W     (6),
    .ERR_W     (6)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  comb_str_checker #(
    .EXP_TABLE (32'hCCCC_F0F0),
    .VEC_TOTAL (20),
    .CNT_W     (6),
    .ERR_W     (4)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe1(input logic [4:0] idx, input logic yv);
    bus1.sel = idx[4]; bus1.a = idx[3]; bus1.b = idx[2];
    bus1.c = idx[1]; bus1.d = idx[0]; bus1.y = yv;
    bus1.sample_en = 1'b1;
    tick();
    bus1.sample_en = 1'b0;
  endtask

  task automatic start1();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    tbl  = 32'hCCCC_F0F0;
    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.sample_en = 1'b0;
    bus1.sel = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b0; bus1.y = 1'b0;
    bus2.start = 1'b0; bus2.sample_en = 1'b0;
    bus2.sel = 1'b0; bus2.a = 1'b0; bus2.b = 1'b0; bus2.c = 1'b0; bus2.d = 1'b0; bus2.y = 1'b0;
    #12;
    chk("rst_busy", {31'd0, bus1.busy}, 32'd0);
    chk("rst_done", {31'd0, bus1.done}, 32'd0);
    chk("rst_pass", {31'd0, bus1.pass}, 32'd0);
    chk("rst_vec", {26'd0, bus1.vec_cnt}, 32'd0);
    chk("rst_cov", bus1.coverage, 32'd0);
    chk("rst_ffv", {31'd0, bus1.first_fail_vld}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: full clean sweep
    start1();
    chk("t1_busy", {31'd0, bus1.busy}, 32'd1);
    for (int i = 0; i < 31; i++) strobe1(5'(i), tbl[i]);
    chk("t1_done_early", {31'd0, bus1.done}, 32'd0);
    chk("t1_vec31", {26'd0, bus1.vec_cnt}, 32'd31);
    strobe1(5'd31, tbl[31]);
    chk("t1_done", {31'd0, bus1.done}, 32'd1);
    chk("t1_busy0", {31'd0, bus1.busy}, 32'd0);
    chk("t1_pass", {31'd0, bus1.pass}, 32'd1);
    chk("t1_vec", {26'd0, bus1.vec_cnt}, 32'd32);
    chk("t1_err", {26'd0, bus1.err_cnt}, 32'd0);
    chk("t1_cov", bus1.coverage, 32'hFFFF_FFFF);
    chk("t1_ffv", {31'd0, bus1.first_fail_vld}, 32'd0);
    tick();
    chk("t1_pass_hold", {31'd0, bus1.pass}, 32'd1);

    // 2: restart from DONE, two injected errors at idx 5 (expected 1) and idx 20 (expected 0)
    start1();
    chk("t2_vec0", {26'd0, bus1.vec_cnt}, 32'd0);
    chk("t2_cov0", bus1.coverage, 32'd0);
    chk("t2_pass0", {31'd0, bus1.pass}, 32'd0);
    chk("t2_done0", {31'd0, bus1.done}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i == 5 || i == 20) strobe1(5'(i), ~tbl[i]);
      else                   strobe1(5'(i), tbl[i]);
    end
    chk("t2_done", {31'd0, bus1.done}, 32'd1);
    chk("t2_err", {26'd0, bus1.err_cnt}, 32'd2);
    chk("t2_ffv", {31'd0, bus1.first_fail_vld}, 32'd1);
    chk("t2_ffidx", {27'd0, bus1.first_fail_idx}, 32'd5);
    chk("t2_ffy", {31'd0, bus1.first_fail_y}, 32'd0);
    chk("t2_pass", {31'd0, bus1.pass}, 32'd0);

    // 3: coverage hole
    start1();
    for (int i = 0; i < 32; i++) strobe1(5'd0, 1'b0);
    chk("t3_done", {31'd0, bus1.done}, 32'd1);
    chk("t3_err", {26'd0, bus1.err_cnt}, 32'd0);
    chk("t3_vec", {26'd0, bus1.vec_cnt}, 32'd32);
    chk("t3_cov", bus1.coverage, 32'h0000_0001);
    chk("t3_pass", {31'd0, bus1.pass}, 32'd0);

    // 4: saturating error counter on the small instance
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus2.sel = i[4]; bus2.a = i[3]; bus2.b = i[2]; bus2.c = i[1]; bus2.d = i[0];
      bus2.y = ~tbl[i];
      bus2.sample_en = 1'b1;
      tick();
      if (i == 9) chk("t4_err10", {28'd0, bus2.err_cnt}, 32'd10);
    end
    bus2.sample_en = 1'b0;
    chk("t4_err", {28'd0, bus2.err_cnt}, 32'd15);
    chk("t4_vec", {26'd0, bus2.vec_cnt}, 32'd20);
    chk("t4_done", {31'd0, bus2.done}, 32'd1);
    chk("t4_pass", {31'd0, bus2.pass}, 32'd0);
    chk("t4_ffidx", {27'd0, bus2.first_fail_idx}, 32'd0);

    // 5: mid-run reset
    start1();
    for (int i = 0; i < 10; i++) strobe1(5'(i), tbl[i]);
    chk("t5_vec10", {26'd0, bus1.vec_cnt}, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("t5_vec", {26'd0, bus1.vec_cnt}, 32'd0);
    chk("t5_cov", bus1.coverage, 32'd0);
    chk("t5_busy", {31'd0, bus1.busy}, 32'd0);
    chk("t5_d2done", {31'd0, bus2.done}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) strobe1(5'(i), tbl[i]);
    chk("t5_idle_vec", {26'd0, bus1.vec_cnt}, 32'd0);
    chk("t5_idle_cov", bus1.coverage, 32'd0);
    chk("t5_idle_busy", {31'd0, bus1.busy}, 32'd0);

    // 6: start ignored in RUN, honoured in DONE, start-cycle strobe dropped
    start1();
    for (int i = 0; i < 3; i++) strobe1(5'(i), tbl[i]);
    bus1.start = 1'b1;
    strobe1(5'd3, tbl[3]);
    bus1.start = 1'b0;
    chk("t6_vec4", {26'd0, bus1.vec_cnt}, 32'd4);
    chk("t6_cov4", bus1.coverage, 32'h0000_000F);
    chk("t6_busy", {31'd0, bus1.busy}, 32'd1);
    for (int i = 4; i < 32; i++) strobe1(5'(i), tbl[i]);
    chk("t6_done", {31'd0, bus1.done}, 32'd1);
    chk("t6_pass", {31'd0, bus1.pass}, 32'd1);
    bus1.start = 1'b1;
    strobe1(5'd7, tbl[7]);
    bus1.start = 1'b0;
    chk("t6_rs_vec", {26'd0, bus1.vec_cnt}, 32'd0);
    chk("t6_rs_cov", bus1.coverage, 32'd0);
    chk("t6_rs_busy", {31'd0, bus1.busy}, 32'd1);
    chk("t6_rs_pass", {31'd0, bus1.pass}, 32'd0);
    strobe1(5'd9, tbl[9]);
    chk("t6_vec1", {26'd0, bus1.vec_cnt}, 32'd1);
    chk("t6_cov1", bus1.coverage, 32'h0000_0200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
